drive_sequencer: RTL and testbench
==================================

// Module: drive_sequencer
// PURPOSE
//  Downstream stage of the pattern buffer. Converts the per-phase drive and tweak bytes into
//  timed gate signals for the output driver pins. Enforces break-before-make dead time on every
//  pwm edge, then times each tweak stage against the programmed delay and sense.
//  All outputs are registered and feed the pad drivers directly.
// PARAMETERS
//  WIDTH        8  pins per driver bank; width of every drive/tweak bus
//  DEAD_CYCLES  2  all-off cycles after each pwm edge; legal range 2..15.
//                  The minimum of 2 covers the 2-cycle lag of the upstream drive bytes behind pwm.
// PORTS
//  clk            in   1      system clock, all logic on rising edge
//  rst_n          in   1      asynchronous active-low reset
//  pwm            in   1      phase select: 1 = high-driving phase, 0 = low-driving phase
//  p_drive        in   WIDTH  p-side enables, active-low (1 = off)
//  n_drive        in   WIDTH  n-side enables, active-high
//  tweak_delay    in   WIDTH  cycles from dead-time end to delay expiry (unsigned)
//  tweak_sense    in   WIDTH  bit k: 0 = stage k active before expiry, 1 = after expiry
//  tweak_drive_0..7 in WIDTH  per-pin enable of tweak stage k (eight separate ports)
//  pgate          out  WIDTH  p gate, active-low
//  ngate          out  WIDTH  n gate, active-high
//  tweak_out_0..7 out  WIDTH  timed tweak stage k enables, active-high
//  seq_state      out  2      state: 0 OFF, 1 DEAD, 2 DELAY, 3 HOLD
// BEHAVIOUR
//  - Reset values: pgate = all 1; ngate = 0; tweak_out_* = 0; seq_state = OFF;
//    pwm_q = 0; dead and delay counters = 0.
//  - Edge detection:
//    - pwm_q samples pwm every cycle.
//    - An edge exists when pwm != pwm_q at a clock edge, or when the state is OFF.
//  - FSM transitions:
//    - OFF -> DEAD on the first clock after reset release, unconditionally.
//    - Any state -> DEAD on edge. Load dead_cnt = DEAD_CYCLES-1 and latch phase = pwm.
//      An edge during DEAD restarts the dead time.
//    - DEAD with dead_cnt == 0 -> DELAY, loading dly_cnt = tweak_delay - 1.
//      If tweak_delay == 0, go directly to HOLD instead.
//    - Otherwise DEAD decrements dead_cnt.
//    - DELAY with dly_cnt == 0 -> HOLD; otherwise DELAY decrements dly_cnt.
//    - tweak_delay is sampled only at that load; later changes are ignored until the next phase.
//    - HOLD persists until the next edge. No counter wraps; counters are WIDTH or 4 bits.
//  - Outputs are registered from next-state, so they change on the same edge as seq_state.
//  - Timing: pwm toggling before edge E0 gives all-off at E0.
//    Drive resumes at E0 + DEAD_CYCLES; delay expires at E0 + DEAD_CYCLES + tweak_delay.
//  - In OFF and DEAD: pgate = all 1, ngate = 0, all tweak_out = 0.
//  - In DELAY or HOLD with phase = 1: pgate = p_drive, ngate = 0.
//  - In DELAY or HOLD with phase = 0: pgate = all 1, ngate = n_drive.
//  - tweak_out_k = tweak_drive_k when (sense[k] == 0 and state == DELAY) or
//    (sense[k] == 1 and state == HOLD); otherwise 0.
//    Drive and tweak inputs are used live every cycle; sense is used live.
//  - Invariant: no pin ever has pgate == 0 and ngate == 1 in the same cycle.
//    This holds across every transition, including simultaneous edge and delay expiry,
//    where the edge wins.
//  - Reset asserted mid-phase forces the reset values immediately (asynchronous).
// STRUCTURE
//  - Shared package pat_drive_pkg:
//    - state encodings SEQ_OFF, SEQ_DEAD, SEQ_DELAY, SEQ_HOLD;
//    - off constants P_OFF = all 1 and N_OFF = 0.
//  - One sub-module, drive_phase_timer: pwm edge detector, FSM, dead and delay counters.
//    It outputs state and phase.
//  - The top level holds the output muxing and registers, with the tweak path generated
//    per stage k.
// TESTING
//  1. Reset release with pwm = 1, DEAD_CYCLES = 2, p_drive = 8'h0F, tweak_delay = 3.
//     Expect: state OFF -> DEAD; pgate = FF for 2 cycles, then 0F; state DELAY for 3 cycles,
//     then HOLD.
//  2. tweak_sense = 8'h01, tweak_drive_0 = 8'hAA, tweak_drive_1 = 8'h55, tweak_delay = 4.
//     Expect: tweak_out_1 = 55 for 4 DELAY cycles, then 0.
//     Expect: tweak_out_0 = 0 during DELAY, AA in HOLD.
//  3. pwm 1 -> 0 with n_drive = 8'hF0.
//     Expect: at the next edge pgate = FF, ngate = 00; after 2 cycles ngate = F0, pgate stays FF.
//     Check no pin has both gates on in any cycle.
//  4. pwm toggles again one cycle into DEAD.
//     Expect: dead time restarts; outputs off for 2 further cycles; the latched phase follows
//     the final pwm.
//  5. tweak_delay = 0: DEAD goes directly to HOLD; sense-0 tweaks never assert.
//     A pwm edge in the same cycle as delay expiry gives DEAD, not HOLD.
//  6. rst_n pulsed low mid-HOLD.
//     Expect: outputs reach reset values without a clock; sequence restarts as in test 1.

Source files
------------

// File: rtl/pat_drive_pkg.sv
// Shared definitions for the pattern-driver datapath: sequencer state
// encodings, safe "all off" gate levels and the tweak window helper.
package pat_drive_pkg;

  // Pins per driver bank and number of tweak stages.
  localparam int PIN_W   = 8;
  localparam int N_TWEAK = 8;

  // Sequencer state, also exported on the seq_state debug port.
  typedef enum logic [1:0] {
    SEQ_OFF   = 2'd0,
    SEQ_DEAD  = 2'd1,
    SEQ_DELAY = 2'd2,
    SEQ_HOLD  = 2'd3
  } seq_state_e;

  // Gate levels that leave every pin undriven (p gate active-low, n gate active-high).
  localparam logic [PIN_W-1:0] P_OFF = '1;
  localparam logic [PIN_W-1:0] N_OFF = '0;

  // A tweak stage with sense 0 is live during DELAY; with sense 1 it is live during HOLD.
  function automatic logic tweak_window(input logic sense, input seq_state_e st);
    return sense ? (st == SEQ_HOLD) : (st == SEQ_DELAY);
  endfunction

endpackage

// File: rtl/drive_phase_timer.sv
// Phase timer: detects pwm edges, runs the OFF/DEAD/DELAY/HOLD sequence and
// the dead/delay counters, and reports both the registered and next state so
// the output stage can register its gates in step with seq_state.
module drive_phase_timer
  import pat_drive_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEAD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_i,
  input  logic [WIDTH-1:0] tweak_delay_i,
  output seq_state_e       state_o,
  output seq_state_e       state_nxt_o,
  output logic             phase_nxt_o
);

  localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic             pwm_q, pwm_d;
  logic             phase_q, phase_d;
  logic [3:0]       dead_cnt_q, dead_cnt_d;
  logic [WIDTH-1:0] dly_cnt_q, dly_cnt_d;
  logic             edge_det;

  // OFF is treated as a permanent edge so the first clock after reset starts a dead time.
  assign edge_det = (pwm_i != pwm_q) || (state_q == SEQ_OFF);

  // State register and counters; reset leaves every pin off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_OFF;
      pwm_q      <= 1'b0;
      phase_q    <= 1'b0;
      dead_cnt_q <= '0;
      dly_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pwm_q      <= pwm_d;
      phase_q    <= phase_d;
      dead_cnt_q <= dead_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
    end
  end

  // Next-state logic: an edge always wins, even on the cycle the delay expires.
  always_comb begin
    state_d    = state_q;
    pwm_d      = pwm_i;
    phase_d    = phase_q;
    dead_cnt_d = dead_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    if (edge_det) begin
      state_d    = SEQ_DEAD;
      dead_cnt_d = DEAD_LOAD;
      phase_d    = pwm_i;
    end else begin
      unique case (state_q)
        SEQ_DEAD: begin
          if (dead_cnt_q == 4'd0) begin
            // tweak_delay is captured only here; later changes wait for the next phase.
            if (tweak_delay_i == '0) begin
              state_d = SEQ_HOLD;
            end else begin
              state_d   = SEQ_DELAY;
              dly_cnt_d = tweak_delay_i - 1'b1;
            end
          end else begin
            dead_cnt_d = dead_cnt_q - 4'd1;
          end
        end
        SEQ_DELAY: begin
          if (dly_cnt_q == '0) state_d = SEQ_HOLD;
          else                 dly_cnt_d = dly_cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: current state for debug, next state and phase for the registered gate stage.
  always_comb begin
    state_o     = state_q;
    state_nxt_o = state_d;
    phase_nxt_o = phase_d;
  end

endmodule

// File: rtl/drive_sequencer.sv
// Drive sequencer top: turns per-phase drive and tweak bytes into registered
// gate signals with break-before-make dead time on every pwm edge. The p and
// n gates are never both enabled because only the latched phase's side is passed.
module drive_sequencer
  import pat_drive_pkg::*;
#(
  parameter int WIDTH       = PIN_W,
  parameter int DEAD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm,
  input  logic [WIDTH-1:0] p_drive,
  input  logic [WIDTH-1:0] n_drive,
  input  logic [WIDTH-1:0] tweak_delay,
  input  logic [WIDTH-1:0] tweak_sense,
  input  logic [WIDTH-1:0] tweak_drive_0,
  input  logic [WIDTH-1:0] tweak_drive_1,
  input  logic [WIDTH-1:0] tweak_drive_2,
  input  logic [WIDTH-1:0] tweak_drive_3,
  input  logic [WIDTH-1:0] tweak_drive_4,
  input  logic [WIDTH-1:0] tweak_drive_5,
  input  logic [WIDTH-1:0] tweak_drive_6,
  input  logic [WIDTH-1:0] tweak_drive_7,
  output logic [WIDTH-1:0] pgate,
  output logic [WIDTH-1:0] ngate,
  output logic [WIDTH-1:0] tweak_out_0,
  output logic [WIDTH-1:0] tweak_out_1,
  output logic [WIDTH-1:0] tweak_out_2,
  output logic [WIDTH-1:0] tweak_out_3,
  output logic [WIDTH-1:0] tweak_out_4,
  output logic [WIDTH-1:0] tweak_out_5,
  output logic [WIDTH-1:0] tweak_out_6,
  output logic [WIDTH-1:0] tweak_out_7,
  output logic [1:0]       seq_state
);

  seq_state_e       state_cur, state_nxt;
  logic             phase_nxt;
  logic             drive_on;
  logic [WIDTH-1:0] pgate_q, pgate_d;
  logic [WIDTH-1:0] ngate_q, ngate_d;
  logic [WIDTH-1:0] tw_drive [N_TWEAK];
  logic [WIDTH-1:0] tw_q     [N_TWEAK];

  drive_phase_timer #(
    .WIDTH       (WIDTH),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm_i         (pwm),
    .tweak_delay_i (tweak_delay),
    .state_o       (state_cur),
    .state_nxt_o   (state_nxt),
    .phase_nxt_o   (phase_nxt)
  );

  assign tw_drive[0] = tweak_drive_0;
  assign tw_drive[1] = tweak_drive_1;
  assign tw_drive[2] = tweak_drive_2;
  assign tw_drive[3] = tweak_drive_3;
  assign tw_drive[4] = tweak_drive_4;
  assign tw_drive[5] = tweak_drive_5;
  assign tw_drive[6] = tweak_drive_6;
  assign tw_drive[7] = tweak_drive_7;

  assign drive_on = (state_nxt == SEQ_DELAY) || (state_nxt == SEQ_HOLD);

  // Gate select from next state: only the side of the latched phase may turn on.
  always_comb begin
    pgate_d = P_OFF;
    ngate_d = N_OFF;
    if (drive_on) begin
      if (phase_nxt) pgate_d = p_drive;
      else           ngate_d = n_drive;
    end
  end

  // Gate registers feeding the pads directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pgate_q <= P_OFF;
      ngate_q <= N_OFF;
    end else begin
      pgate_q <= pgate_d;
      ngate_q <= ngate_d;
    end
  end

  for (genvar k = 0; k < N_TWEAK; k++) begin : g_tweak
    // Tweak stage k register: passes its live enables only inside its sense window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tw_q[k] <= '0;
      else        tw_q[k] <= tweak_window(tweak_sense[k], state_nxt) ? tw_drive[k] : '0;
    end
  end

  assign pgate       = pgate_q;
  assign ngate       = ngate_q;
  assign tweak_out_0 = tw_q[0];
  assign tweak_out_1 = tw_q[1];
  assign tweak_out_2 = tw_q[2];
  assign tweak_out_3 = tw_q[3];
  assign tweak_out_4 = tw_q[4];
  assign tweak_out_5 = tw_q[5];
  assign tweak_out_6 = tw_q[6];
  assign tweak_out_7 = tw_q[7];
  assign seq_state   = state_cur;

endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: directed phase scenarios followed by random
// pwm/drive traffic, checked cycle by cycle against a timeline model.
module tb_drive_sequencer;

  localparam int W  = 8;
  localparam int DC = 2;
  localparam int EW = 2 + W + W + 8 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         pwm;
  logic [W-1:0] p_drive, n_drive, tweak_delay, tweak_sense;
  logic [W-1:0] twd [8];
  logic [W-1:0] pgate, ngate;
  logic [W-1:0] to0, to1, to2, to3, to4, to5, to6, to7;
  logic [1:0]   seq_state;
  logic [8*W-1:0] tout_all;

  assign tout_all = {to7, to6, to5, to4, to3, to2, to1, to0};

  drive_sequencer #(.WIDTH(W), .DEAD_CYCLES(DC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm           (pwm),
    .p_drive       (p_drive),
    .n_drive       (n_drive),
    .tweak_delay   (tweak_delay),
    .tweak_sense   (tweak_sense),
    .tweak_drive_0 (twd[0]),
    .tweak_drive_1 (twd[1]),
    .tweak_drive_2 (twd[2]),
    .tweak_drive_3 (twd[3]),
    .tweak_drive_4 (twd[4]),
    .tweak_drive_5 (twd[5]),
    .tweak_drive_6 (twd[6]),
    .tweak_drive_7 (twd[7]),
    .pgate         (pgate),
    .ngate         (ngate),
    .tweak_out_0   (to0),
    .tweak_out_1   (to1),
    .tweak_out_2   (to2),
    .tweak_out_3   (to3),
    .tweak_out_4   (to4),
    .tweak_out_5   (to5),
    .tweak_out_6   (to6),
    .tweak_out_7   (to7),
    .seq_state     (seq_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Reset values checked directly, with no clock edge involved.
  task automatic check_reset_now(input string tag);
    check({tag, "_state"}, 64'(seq_state), 64'd0);
    check({tag, "_pgate"}, 64'(pgate), 64'hFF);
    check({tag, "_ngate"}, 64'(ngate), 64'h00);
    check({tag, "_tweak"}, tout_all, 64'h0);
  endtask

  // ---------------- reference model ----------------
  // Timeline view: cycles since the last phase start decide the state.
  // 0..DC-1 is dead time, then td cycles of delay, then hold.
  bit   m_off   = 1'b1;
  logic m_prev  = 1'b0;
  logic m_phase = 1'b0;
  int   m_since = 0;
  int   m_td    = 0;

  always @(posedge clk) begin : model
    logic [1:0]     st;
    logic [W-1:0]   pg, ng;
    logic [8*W-1:0] tw;
    if (!rst_n) begin
      m_off  = 1'b1;
      m_prev = 1'b0;
      exp_q.push_back({2'd0, 8'hFF, 8'h00, 64'h0});
    end else begin
      if (m_off || (pwm !== m_prev)) begin
        m_off   = 1'b0;
        m_phase = pwm;
        m_since = 0;
      end else begin
        m_since++;
        if (m_since == DC) m_td = int'(tweak_delay);
      end
      m_prev = pwm;
      if (m_since < DC)               st = 2'd1;
      else if (m_since - DC < m_td)   st = 2'd2;
      else                            st = 2'd3;
      pg = (st != 2'd1 &&  m_phase) ? p_drive : 8'hFF;
      ng = (st != 2'd1 && !m_phase) ? n_drive : 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (tweak_sense[k] ? (st == 2'd3) : (st == 2'd2)) tw[k*W +: W] = twd[k];
        else                                              tw[k*W +: W] = '0;
      end
      exp_q.push_back({st, pg, ng, tw});
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin : monitor
    logic [EW-1:0] e;
    #1;
    check("overlap", 64'(~pgate & ngate), 64'h0);
    if (exp_q.size() == 0) begin
      check("exp_queue_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("seq_state", 64'(seq_state), 64'(e[EW-1 -: 2]));
      check("pgate",     64'(pgate),     64'(e[EW-3 -: W]));
      check("ngate",     64'(ngate),     64'(e[EW-3-W -: W]));
      check("tweak_out", tout_all,       e[8*W-1:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic randomize_bytes();
    p_drive = 8'($urandom_range(0, 255));
    n_drive = 8'($urandom_range(0, 255));
    tweak_sense = 8'($urandom_range(0, 255));
    for (int k = 0; k < 8; k++) twd[k] = 8'($urandom_range(0, 255));
  endtask

  // Async reset pulse between clock edges, released on a falling edge.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_now(tag);
    cycles(2);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pwm = 1'b0; p_drive = '1; n_drive = '0; tweak_delay = '0; tweak_sense = '0;
    for (int k = 0; k < 8; k++) twd[k] = '0;

    #1 rst_n = 1'b0;
    #1 check_reset_now("por");
    cycles(2);

    // Reset release with pwm high: 2 dead cycles, 3 delay cycles, then hold.
    pwm = 1'b1; p_drive = 8'h0F; tweak_delay = 8'd3;
    rst_n = 1'b1;
    cycles(8);

    // Sense split: stage 1 during delay, stage 0 in hold; new phase via pwm low.
    tweak_sense = 8'h01; twd[0] = 8'hAA; twd[1] = 8'h55; tweak_delay = 8'd4;
    n_drive = 8'hF0; pwm = 1'b0;
    cycles(10);

    // Phase flip back to high, then high to low with n_drive F0.
    pwm = 1'b1; cycles(8);
    pwm = 1'b0; cycles(8);

    // Toggle again one cycle into dead time: dead time restarts, phase follows final pwm.
    pwm = 1'b1; cycles(1);
    pwm = 1'b0; cycles(8);

    // Zero delay: dead time goes straight to hold.
    tweak_delay = 8'd0; tweak_sense = 8'h0F;
    pwm = 1'b1; cycles(6);

    // Edge landing on the delay expiry cycle: dead time wins.
    tweak_delay = 8'd3;
    pwm = 1'b0; cycles(DC + 3);
    pwm = 1'b1; cycles(8);

    // Reset mid-hold, then the power-up sequence again.
    reset_pulse("midhold");
    pwm = 1'b1; p_drive = 8'h0F; tweak_delay = 8'd3;
    cycles(8);

    // Random traffic: live bytes every cycle, pwm toggles at random spacing.
    for (int i = 0; i < 3000; i++) begin
      randomize_bytes();
      if ($urandom_range(0, 3) == 0) pwm = ~pwm;
      if ($urandom_range(0, 7) == 0) tweak_delay = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 999) == 0) reset_pulse("rand_rst");
      else cycles(1);
    end

    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
